// File: rtl/pwm_multi.sv
// pwm_multi: NumChannels PWM outputs driven from one shared period counter.
//
// Software writes the pending inputs (max_counter_i, pulse_width_i,
// chan_en_i, invert_i) at any time. They are copied into the active
// shadow set only while the block is idle (enable_i low) or on the last
// count of a period. A mid-period write therefore never produces a
// shortened or split pulse. It takes effect on the first cycle of the
// next period.
//
// The counter wraps when it equals max_q, so the period is max_q+1
// cycles. It never relies on width overflow. Every output is registered
// and follows the counter value of the previous cycle. period_o lines up
// with the output of the last count in each period.

module pwm_multi #(
   parameter int NumChannels = 12,
   parameter int CtrSize     = 8
) (
   input  logic                             clk_sys_i,
   input  logic                             rst_sys_ni,
   input  logic                             enable_i,
   input  logic [CtrSize-1:0]               max_counter_i,
   input  logic [NumChannels*CtrSize-1:0]   pulse_width_i,
   input  logic [NumChannels-1:0]           chan_en_i,
   input  logic [NumChannels-1:0]           invert_i,
   output logic [NumChannels-1:0]           modulated_o,
   output logic                             period_o
);

   logic [CtrSize-1:0]                    ctr_q;
   logic [CtrSize-1:0]                    max_q;
   logic [NumChannels-1:0][CtrSize-1:0]   duty_q;
   logic [NumChannels-1:0]                en_q;
   logic [NumChannels-1:0]                inv_q;
   logic [NumChannels-1:0]                out_q;
   logic                                  period_q;

   logic                                  wrap;
   logic                                  load;
   logic [NumChannels-1:0]                raw;

   // The last count of a period only exists while the block is running.
   assign wrap = enable_i && (ctr_q == max_q);

   // Shadows track the pending inputs while the block is idle. While it runs,
   // they are captured only at the period boundary.
   assign load = !enable_i || wrap;

   // Unsigned compare of the shared counter against each channel's active duty.
   always_comb begin
      raw = '0;
      for (int i = 0; i < NumChannels; i++) begin
         raw[i] = (ctr_q < duty_q[i]);
      end
   end

   // The period counter restarts from zero when the block is idle or at the period end.
   always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
      if (!rst_sys_ni) begin
         ctr_q <= '0;
      end else if (load) begin
         ctr_q <= '0;
      end else begin
         ctr_q <= ctr_q + CtrSize'(1);
      end
   end

   // Double-buffered active configuration.
   // The packed duty array lines up bit-for-bit with pulse_width_i.
   always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
      if (!rst_sys_ni) begin
         max_q  <= '0;
         duty_q <= '0;
         en_q   <= '0;
         inv_q  <= '0;
      end else if (load) begin
         max_q  <= max_counter_i;
         duty_q <= pulse_width_i;
         en_q   <= chan_en_i;
         inv_q  <= invert_i;
      end
   end

   // Registered outputs.
   // The idle level uses the pending polarity, so it follows software at once.
   always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
      if (!rst_sys_ni) begin
         out_q    <= '0;
         period_q <= 1'b0;
      end else begin
         if (!enable_i) begin
            out_q <= invert_i;
         end else begin
            out_q <= (en_q & raw) ^ inv_q;
         end
         period_q <= wrap;
      end
   end

   assign modulated_o = out_q;
   assign period_o    = period_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Directed testbench for pwm_multi with NumChannels=12 and CtrSize=8.
// Inputs change 1 ns after a rising edge, and outputs are sampled at the same point.
// Sample k of a run is taken after the k-th rising edge with enable_i high.

module tb_pwm_multi;

   localparam int NumChannels = 12;
   localparam int CtrSize     = 8;

   logic                            clk_sys_i = 1'b0;
   logic                            rst_sys_ni;
   logic                            enable_i;
   logic [CtrSize-1:0]              max_counter_i;
   logic [NumChannels*CtrSize-1:0]  pulse_width_i;
   logic [NumChannels-1:0]          chan_en_i;
   logic [NumChannels-1:0]          invert_i;
   logic [NumChannels-1:0]          modulated_o;
   logic                            period_o;

   int n_tests = 0;
   int n_fail  = 0;

   int                      hi_cnt [NumChannels];
   int                      per_cnt;
   int                      n_samp;
   logic [63:0]             pat0;
   logic [63:0]             pat1;
   logic [63:0]             per_pat;
   logic [NumChannels-1:0]  first_out;
   logic [NumChannels-1:0]  last_out;
   logic                    last_per;
   logic [NumChannels*CtrSize-1:0] pw;

   pwm_multi #(
      .NumChannels (NumChannels),
      .CtrSize     (CtrSize)
   ) dut (
      .clk_sys_i     (clk_sys_i),
      .rst_sys_ni    (rst_sys_ni),
      .enable_i      (enable_i),
      .max_counter_i (max_counter_i),
      .pulse_width_i (pulse_width_i),
      .chan_en_i     (chan_en_i),
      .invert_i      (invert_i),
      .modulated_o   (modulated_o),
      .period_o      (period_o)
   );

   always #5 clk_sys_i = ~clk_sys_i;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear();
      for (int c = 0; c < NumChannels; c++) hi_cnt[c] = 0;
      per_cnt   = 0;
      n_samp    = 0;
      pat0      = '0;
      pat1      = '0;
      per_pat   = '0;
      first_out = '0;
      last_out  = '0;
      last_per  = 1'b0;
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk_sys_i);
         #1;
         if (n_samp == 0) first_out = modulated_o;
         if (n_samp < 64) begin
            pat0[n_samp]    = modulated_o[0];
            pat1[n_samp]    = modulated_o[1];
            per_pat[n_samp] = period_o;
         end
         for (int c = 0; c < NumChannels; c++) begin
            if (modulated_o[c]) hi_cnt[c]++;
         end
         if (period_o) per_cnt++;
         last_out = modulated_o;
         last_per = period_o;
         n_samp++;
      end
   endtask

   // Idle for one edge with the new configuration, check the idle level, then re-enable.
   task automatic restart(input logic [CtrSize-1:0] mx,
                          input logic [NumChannels*CtrSize-1:0] pwv,
                          input logic [NumChannels-1:0] en,
                          input logic [NumChannels-1:0] inv);
      enable_i      = 1'b0;
      max_counter_i = mx;
      pulse_width_i = pwv;
      chan_en_i     = en;
      invert_i      = inv;
      @(posedge clk_sys_i);
      #1;
      check("idle_level", 64'(modulated_o), 64'(inv));
      check("idle_period", 64'(period_o), 64'd0);
      enable_i = 1'b1;
      clear();
   endtask

   initial begin
      rst_sys_ni    = 1'b0;
      enable_i      = 1'b0;
      max_counter_i = '0;
      pulse_width_i = '0;
      chan_en_i     = '0;
      invert_i      = '0;
      clear();

      // Reset state, including edges while reset is held and a pending idle level of 1.
      #12;
      check("rst_out", 64'(modulated_o), 64'd0);
      check("rst_period", 64'(period_o), 64'd0);
      invert_i = '1;
      @(posedge clk_sys_i);
      #1;
      check("rst_hold_out", 64'(modulated_o), 64'd0);
      invert_i = '0;
      #2;
      rst_sys_ni = 1'b1;

      // Basic duty: max 9, ch0 duty 3.
      pw = '0;
      pw[7:0] = 8'd3;
      restart(8'd9, pw, 12'h001, 12'h000);
      run(20);
      check("basic_pat", pat0[19:0], 20'h01C07);
      check("basic_per_pat", per_pat[19:0], 20'h80200);
      check("basic_hi", 64'(hi_cnt[0]), 64'd6);
      check("basic_disabled_ch1", 64'(hi_cnt[1]), 64'd0);

      // Double buffering: the change after sample 2 lands at sample 10.
      clear();
      run(3);
      max_counter_i       = 8'd4;
      pulse_width_i[7:0]  = 8'd7;
      run(17);
      check("dbuf_pat", pat0[19:0], 20'hFFC07);
      check("dbuf_per_pat", per_pat[19:0], 20'h84200);

      // duty 0 gives an output that is always inactive.
      pw = '0;
      restart(8'd9, pw, 12'h001, 12'h000);
      run(20);
      check("duty0_hi", 64'(hi_cnt[0]), 64'd0);
      check("duty0_per", 64'(per_cnt), 64'd2);

      // duty = max+1 gives an output that is always active.
      pw = '0;
      pw[7:0] = 8'd10;
      restart(8'd9, pw, 12'h001, 12'h000);
      run(20);
      check("dutymax1_hi", 64'(hi_cnt[0]), 64'd20);

      // duty 255 with max 255 is high for 255 of 256 cycles.
      pw = '0;
      pw[7:0] = 8'd255;
      restart(8'd255, pw, 12'h001, 12'h000);
      run(256);
      check("d255_hi", 64'(hi_cnt[0]), 64'd255);
      check("d255_per", 64'(per_cnt), 64'd1);
      check("d255_last_out", 64'(last_out[0]), 64'd0);
      check("d255_last_per", 64'(last_per), 64'd1);

      // max 0 gives a 1-cycle period.
      pw = '0;
      pw[7:0] = 8'd1;
      restart(8'd0, pw, 12'h001, 12'h000);
      run(8);
      check("max0_hi", 64'(hi_cnt[0]), 64'd8);
      check("max0_per", 64'(per_cnt), 64'd8);

      // A disabled channel with inverted polarity sits at 1.
      pw = '0;
      pw[7:0] = 8'd3;
      restart(8'd9, pw, 12'h000, 12'h001);
      run(20);
      check("inv_dis_hi", 64'(hi_cnt[0]), 64'd20);
      check("inv_dis_per", 64'(per_cnt), 64'd2);

      // enable_i drops mid-period, then the block re-enables.
      pw = '0;
      pw[7:0]  = 8'd3;
      pw[15:8] = 8'd3;
      restart(8'd9, pw, 12'h003, 12'h002);
      run(5);
      check("drop_pre_pat0", pat0[4:0], 5'b00111);
      check("drop_pre_pat1", pat1[4:0], 5'b11000);
      check("drop_pre_per", 64'(per_cnt), 64'd0);
      enable_i = 1'b0;
      @(posedge clk_sys_i);
      #1;
      check("drop_idle_out", 64'(modulated_o), 64'h002);
      check("drop_idle_per", 64'(period_o), 64'd0);
      enable_i = 1'b1;
      clear();
      run(10);
      check("reen_pat0", pat0[9:0], 10'h007);
      check("reen_pat1", pat1[9:0], 10'h3F8);
      check("reen_per_pat", per_pat[9:0], 10'h200);

      // Multi-channel: channel i has duty i and max is 15.
      pw = '0;
      for (int i = 0; i < NumChannels; i++) pw[i*CtrSize +: CtrSize] = CtrSize'(i);
      restart(8'd15, pw, 12'hFFF, 12'h000);
      run(16);
      check("multi_first", 64'(first_out), 64'hFFE);
      check("multi_per_pat", per_pat[15:0], 16'h8000);
      for (int i = 0; i < NumChannels; i++) begin
         check($sformatf("multi_hi_ch%0d", i), 64'(hi_cnt[i]), 64'(i));
      end

      // Asynchronous reset between edges mid-period.
      clear();
      run(5);
      check("arst_pre_out", 64'(modulated_o), 64'hFE0);
      #2;
      rst_sys_ni = 1'b0;
      #1;
      check("arst_out", 64'(modulated_o), 64'd0);
      check("arst_per", 64'(period_o), 64'd0);
      @(posedge clk_sys_i);
      #3;
      rst_sys_ni = 1'b1;
      // After reset the active max is 0, so the first edge is a 1-cycle wrap that loads the shadows.
      clear();
      run(1);
      check("arst_first_out", 64'(modulated_o), 64'd0);
      check("arst_first_per", 64'(period_o), 64'd1);
      clear();
      run(16);
      check("arst_multi_first", 64'(first_out), 64'hFFE);
      check("arst_per_pat", per_pat[15:0], 16'h8000);
      for (int i = 0; i < NumChannels; i++) begin
         check($sformatf("arst_hi_ch%0d", i), 64'(hi_cnt[i]), 64'(i));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
- Parametrised successor to the single-channel pwm block: NumChannels PWM outputs share one period counter, replacing the per-LED pwm instance array in the FPGA top levels.
- Adds global enable, per-channel enable and polarity, and double-buffered duty/period registers that update only at period boundaries, so software writes from the demo system GPO never cause glitched pulses.
- One period-end strobe per period, for software or interrupt sync.

Parameters:
- NumChannels, 12, number of PWM outputs (1..32).
- CtrSize, 8, counter/duty/period width in bits (2..16).

Ports:
- clk_sys_i  input  1  system clock.
- rst_sys_ni  input  1  reset; asynchronous assert, active-low.
- enable_i  input  1  global run enable.
- max_counter_i  input  CtrSize  pending period value; period = max_counter_i+1 cycles.
- pulse_width_i  input  NumChannels*CtrSize  pending duties; channel i at bits [i*CtrSize +: CtrSize].
- chan_en_i  input  NumChannels  pending per-channel enable.
- invert_i  input  NumChannels  pending per-channel polarity; 1 = active-low output.
- modulated_o  output  NumChannels  registered PWM outputs.
- period_o  output  1  one-cycle strobe at each period end.

Behaviour:
- Clock and reset: one clock, clk_sys_i. Reset is asynchronous and active-low on rst_sys_ni.
- Reset values: ctr_q=0; active max/duty/chan_en/invert=0; modulated_o=0; period_o=0.
- Registers:
  - Counter ctr_q, CtrSize bits.
  - Active shadow set: max_q, duty_q[i], en_q[i], inv_q[i].
  - Output register out_q (drives modulated_o) and period_q (drives period_o).
- Wrap: wrap = enable_i && (ctr_q == max_q).
- Counter:
  - enable_i=0: ctr_q <= 0.
  - wrap: ctr_q <= 0.
  - Otherwise: ctr_q <= ctr_q+1.
  - Wrap is by comparison only, never by width overflow.
- Shadow load: active set <= pending inputs on any edge where enable_i=0 or wrap=1. Otherwise held.
  - Pending changes mid-period take effect on the first cycle of the next period.
- Raw compare: raw[i] = (ctr_q < duty_q[i]), unsigned, CtrSize wide.
- Output register each edge:
  - enable_i=0: out_q[i] <= invert_i[i] (idle level uses the pending polarity).
  - enable_i=1: out_q[i] <= (en_q[i] & raw[i]) ^ inv_q[i].
- Latency: modulated_o reflects the counter value of the previous cycle (1-cycle latency).
- period_o: period_q <= wrap. High for exactly one cycle, the cycle after ctr_q==max_q, aligned with the output of the last count of the period.
- Boundary conditions:
  - duty=0: output always inactive.
  - duty > max_q: output always active (100%). duty == max_q+1 gives the same result.
  - max_q=0: period of 1 cycle; ctr_q stays 0; wrap every cycle; period_o constantly 1 while enabled.
  - Disabled channel (en_q=0): output equals inv_q, i.e. its idle level.
  - enable_i falls mid-period: counter cleared next edge, outputs go to idle, no period_o pulse.
  - enable_i rises: first enabled cycle has ctr_q=0 with freshly loaded shadows.
  - Reset asserted mid-operation: all state cleared immediately, without waiting for a clock edge.
- Synthesis: no combinational path from inputs to outputs. All comparisons unsigned.

Test Plan:
- Basic duty: CtrSize=8, max=9, ch0 duty=3, en=1, inv=0, enable_i=1 -> modulated_o[0] high 3 cycles, low 7 per 10-cycle period; period_o pulses every 10 cycles, coincident with the 10th output cycle.
- Double buffering: mid-period change duty 3->7 and max 9->4 -> current period finishes with 3/10; next period shows 5-cycle period, always high (7>4); period_o spacing changes 10->5.
- Extremes: duty=0 -> constant 0; duty=255 with max=255 -> high 255 of 256 cycles; max=0, duty=1 -> constant 1 and period_o held 1.
- Enable/polarity: inv=1, en=0 -> constant 1; enable_i low mid-period -> counter restarts at 0, outputs at idle level next cycle, no period_o pulse until a full period completes after re-enable.
- Multi-channel: NumChannels=12, channel i duty=i, max=15 -> channel i high exactly i of 16 cycles, all rising on the same cycle.
- Async reset: assert rst_sys_ni low between clock edges mid-period -> outputs and period_o 0 immediately; after release with enable_i=1, first period starts at ctr_q=0.
